agc_timepulse_stage_gen: RTL

- Generates the time-pulse and phase timing that drives the stage/branch control logic: T01–T12 time pulses and the PHS2/PHS3/PHS4 phase strobes.
- Holds the 2-bit stage register ST1/ST2, which is loaded from the stage requests (ST1D, STD2) that the control logic returns.
- Handles GOJAM restart, RSTSTG stage clear and monitor stop (MSTP).
- Sits upstream of the stage/branch control module and closes its stage-request loop.

---
 rtl/agc_timepulse_stage_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/agc_timepulse_stage_gen.sv
// agc_timepulse_stage_gen: T01-T12 time pulses, phase strobes and the ST1/ST2 stage register
module agc_timepulse_stage_gen #(
  parameter int PHASES = 4,
  parameter int NTP = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic GOJAM,
  input  logic RSTSTG,
  input  logic ST1D,
  input  logic STD2,
  input  logic MSTP,
  output logic T01,
  output logic T01_,
  output logic T02_,
  output logic T03_,
  output logic T04_,
  output logic T05_,
  output logic T06_,
  output logic T07_,
  output logic T08_,
  output logic T09_,
  output logic T10_,
  output logic T11_,
  output logic T12_,
  output logic PHS2_,
  output logic PHS3_,
  output logic PHS4,
  output logic PHS4_,
  output logic ST1,
  output logic ST2,
  output logic MCTEND,
  output logic STOPPED
);
  localparam logic [3:0] PL = 4'(PHASES);
  if (PHASES < 4 || PHASES > 8 || NTP != 12) begin : g_bad_param
    $error("agc_timepulse_stage_gen: PHASES must be 4..8 and NTP must be 12");
  end
  logic [3:0] t, p;
  logic [2:1] st;
  logic r1, r2, stop, bnd;
  logic [12:1] tn;
  // a frozen stop sits at t=12/p=PHASES but is not itself a boundary cycle
  assign bnd = t == 4'd12 && p == PL && !stop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      t <= 4'd1;
      p <= 4'd1;
      st <= '0;
      r1 <= 1'b0;
      r2 <= 1'b0;
      stop <= 1'b0;
    end else if (GOJAM) begin
      t <= 4'd1;
      p <= 4'd1;
      st <= '0;
      r1 <= 1'b0;
      r2 <= 1'b0;
      stop <= 1'b0;
    end else begin
      if (stop) begin
        if (!MSTP) begin
          t <= 4'd1;
          p <= 4'd1;
          stop <= 1'b0;
        end
      end else if (bnd && MSTP) stop <= 1'b1;
      else if (p == PL) begin
        p <= 4'd1;
        t <= t == 4'd12 ? 4'd1 : t + 4'd1;
      end else p <= p + 4'd1;
      if (RSTSTG) begin
        st <= '0;
        r1 <= 1'b0;
        r2 <= 1'b0;
      end else if (bnd) begin
        st <= {r2 | STD2, r1 | ST1D};
        r1 <= 1'b0;
        r2 <= 1'b0;
      end else begin
        r1 <= r1 | ST1D;
        r2 <= r2 | STD2;
      end
    end
  assign tn = ~(12'd1 << (t - 4'd1));
  assign T01 = ~tn[1];
  assign T01_ = tn[1];
  assign T02_ = tn[2];
  assign T03_ = tn[3];
  assign T04_ = tn[4];
  assign T05_ = tn[5];
  assign T06_ = tn[6];
  assign T07_ = tn[7];
  assign T08_ = tn[8];
  assign T09_ = tn[9];
  assign T10_ = tn[10];
  assign T11_ = tn[11];
  assign T12_ = tn[12];
  assign PHS2_ = p != 4'd2;
  assign PHS3_ = p != 4'd3;
  assign PHS4 = p == PL;
  assign PHS4_ = p != PL;
  assign ST1 = st[1];
  assign ST2 = st[2];
  assign MCTEND = bnd;
  assign STOPPED = stop;
endmodule
